// File: rtl/dmem_arbiter.sv
// dmem_arbiter: sequencer and round-robin two-port arbiter for the shared
// 64-bit data memory. Port 0 is the core load/store path, port 1 is the
// debug/program-loader port. Each transaction latches address/data, drives
// the memory for one access cycle, waits the read latency and returns a
// single-cycle ACK to the granted port.
module dmem_arbiter #(
    parameter int unsigned MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        srst,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [63:0] addr0,
    input  logic [63:0] addr1,
    input  logic [63:0] wdata0,
    input  logic [63:0] wdata1,
    output logic        ack0,
    output logic        ack1,
    output logic [63:0] rdata0,
    output logic [63:0] rdata1,
    output logic [63:0] mem_raddr,
    output logic [63:0] mem_waddr,
    output logic [63:0] mem_din,
    input  logic [63:0] mem_dout,
    output logic        mem_wr,
    output logic        busy,
    output logic        grant
);

    // Wait-counter reload value: the last WAIT cycle is the one with count 0.
    localparam logic [2:0] LAT_M1 = 3'(MEM_LAT - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    state_t      state_r;
    state_t      next_state_s;

    // Transaction registers (latched at the grant edge)
    logic        we_r;
    logic [63:0] addr_r;
    logic [63:0] wdata_r;

    // Control registers
    logic [2:0]  cnt_r;
    logic        last_r;
    logic        grant_r;
    logic        ack0_r;
    logic        ack1_r;
    logic        mem_wr_r;
    logic        busy_r;
    logic [63:0] rdata0_r;
    logic [63:0] rdata1_r;

    // Combinational next values
    logic        win_s;
    logic        latch_s;
    logic        capture_s;
    logic        sel_we_s;
    logic [63:0] sel_addr_s;
    logic [63:0] sel_wdata_s;
    logic [2:0]  cnt_nxt_s;
    logic        ack0_nxt_s;
    logic        ack1_nxt_s;
    logic        mem_wr_nxt_s;
    logic        busy_nxt_s;

    // Round-robin pick: a lone requester wins, a tie goes to the port that
    // did not win last time.
    function automatic logic pick_winner(
        input logic r0,
        input logic r1,
        input logic last
    );
        logic w;
        if (r0 && r1) begin
            w = ~last;
        end else if (r1) begin
            w = 1'b1;
        end else begin
            w = 1'b0;
        end
        return w;
    endfunction

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else if (srst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req0 || req1) begin
                    next_state_s = ST_ACCESS;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (we_r) begin
                    next_state_s = ST_RESP;
                end else begin
                    next_state_s = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_r == 3'd0) begin
                    next_state_s = ST_RESP;
                end else begin
                    next_state_s = ST_WAIT;
                end
            end
            ST_RESP: begin
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Output/datapath next values: winner selection, counter, strobes
    always_comb begin
        win_s     = pick_winner(req0, req1, last_r);
        latch_s   = 1'b0;
        capture_s = 1'b0;
        cnt_nxt_s = cnt_r;
        case (state_r)
            ST_IDLE: begin
                latch_s   = req0 | req1;
                cnt_nxt_s = 3'd0;
            end
            ST_ACCESS: begin
                if (we_r) begin
                    cnt_nxt_s = 3'd0;
                end else begin
                    cnt_nxt_s = LAT_M1;
                end
            end
            ST_WAIT: begin
                if (cnt_r == 3'd0) begin
                    capture_s = 1'b1;
                    cnt_nxt_s = 3'd0;
                end else begin
                    cnt_nxt_s = cnt_r - 3'd1;
                end
            end
            ST_RESP: begin
                cnt_nxt_s = 3'd0;
            end
            default: begin
                cnt_nxt_s = 3'd0;
            end
        endcase

        if (win_s) begin
            sel_we_s    = we1;
            sel_addr_s  = addr1;
            sel_wdata_s = wdata1;
        end else begin
            sel_we_s    = we0;
            sel_addr_s  = addr0;
            sel_wdata_s = wdata0;
        end

        // RESP is only ever entered from ACCESS or WAIT, so grant_r already
        // names the owner of the finishing transaction.
        ack0_nxt_s   = (next_state_s == ST_RESP) && (grant_r == 1'b0);
        ack1_nxt_s   = (next_state_s == ST_RESP) && (grant_r == 1'b1);
        mem_wr_nxt_s = latch_s && sel_we_s;
        busy_nxt_s   = (next_state_s != ST_IDLE);
    end

    // Control and strobe registers; all outputs come straight from flops so
    // a reset clears MEM_WR/ACK/BUSY immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r    <= 3'd0;
            last_r   <= 1'b1;
            grant_r  <= 1'b0;
            ack0_r   <= 1'b0;
            ack1_r   <= 1'b0;
            mem_wr_r <= 1'b0;
            busy_r   <= 1'b0;
        end else if (srst) begin
            cnt_r    <= 3'd0;
            last_r   <= 1'b1;
            grant_r  <= 1'b0;
            ack0_r   <= 1'b0;
            ack1_r   <= 1'b0;
            mem_wr_r <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            cnt_r    <= cnt_nxt_s;
            ack0_r   <= ack0_nxt_s;
            ack1_r   <= ack1_nxt_s;
            mem_wr_r <= mem_wr_nxt_s;
            busy_r   <= busy_nxt_s;
            if (latch_s) begin
                last_r  <= win_s;
                grant_r <= win_s;
            end else begin
                last_r  <= last_r;
                grant_r <= grant_r;
            end
        end
    end

    // Transaction registers: capture the winner's request at the grant edge
    // and hold it (also through IDLE) until the next grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_r    <= 1'b0;
            addr_r  <= 64'd0;
            wdata_r <= 64'd0;
        end else if (srst) begin
            we_r    <= 1'b0;
            addr_r  <= 64'd0;
            wdata_r <= 64'd0;
        end else if (latch_s) begin
            we_r    <= sel_we_s;
            addr_r  <= sel_addr_s;
            wdata_r <= sel_wdata_s;
        end else begin
            we_r    <= we_r;
            addr_r  <= addr_r;
            wdata_r <= wdata_r;
        end
    end

    // Read-data registers: only the granted port's register is updated, and
    // only on the final WAIT cycle of a read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata0_r <= 64'd0;
            rdata1_r <= 64'd0;
        end else if (srst) begin
            rdata0_r <= 64'd0;
            rdata1_r <= 64'd0;
        end else if (capture_s && (grant_r == 1'b0)) begin
            rdata0_r <= mem_dout;
            rdata1_r <= rdata1_r;
        end else if (capture_s && (grant_r == 1'b1)) begin
            rdata0_r <= rdata0_r;
            rdata1_r <= mem_dout;
        end else begin
            rdata0_r <= rdata0_r;
            rdata1_r <= rdata1_r;
        end
    end

    assign ack0      = ack0_r;
    assign ack1      = ack1_r;
    assign rdata0    = rdata0_r;
    assign rdata1    = rdata1_r;
    assign mem_raddr = addr_r;
    assign mem_waddr = addr_r;
    assign mem_din   = wdata_r;
    assign mem_wr    = mem_wr_r;
    assign busy      = busy_r;
    assign grant     = grant_r;

endmodule
